// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory stage: word width, request opcodes,
// read/write direction encoding, FSM state type, and a request-validity helper.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_W = 32;

    // Internal opcodes latched at accept; they carry the access direction
    // through the wait states.
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    // Encoding of the RW input.
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // A request is well formed when exactly one of LDR/STR is raised and RW
    // points the same way. Anything else is rejected without an access.
    function automatic logic req_valid(input logic ldr, input logic str, input logic rw);
        return (ldr && !str && (rw == RW_READ)) ||
               (str && !ldr && (rw == RW_WRITE));
    endfunction

endpackage : mem_pkg

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Down-counter that times the wait states between accept and access.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset (count cleared to 0)
//   load      in   load load_val this edge (has priority over dec)
//   load_val  in   CNT_W value to load
//   dec       in   decrement this edge (ignored once the count is zero)
//   zero      out  count == 0
// -----------------------------------------------------------------------------
module wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule : wait_counter

// File: rtl/data_mem_unit.sv
// -----------------------------------------------------------------------------
// data_mem_unit
// Data-memory stage downstream of memory_control. Accepts one LDR/STR request
// in IDLE, waits WAIT_STATES cycles, then performs a single 32-bit word access
// on an internal synchronous RAM of 2**ADDR_W words.
//
// Ports:
//   Clk       in   clock, rising edge
//   Reset     in   asynchronous active-low reset
//   LDR       in   load request
//   STR       in   store request
//   RW        in   direction: 1 = read, 0 = write
//   add_bus   in   byte address; word index = add_bus[ADDR_W+1:2]
//   data_bus  in   store data
//   rd_data   out  registered load result, held until the next load completes
//   rd_valid  out  one-cycle pulse when rd_data is updated by a load
//   done      out  one-cycle pulse when an access completes or a request is rejected
//   busy      out  access in progress; upstream must hold or stall
//   err       out  one-cycle pulse on a rejected (or faulted) request
//
// Optional build macro MEM_BOUNDS_CHECK_EN: when defined, an accepted access
// whose address is misaligned or beyond the RAM is suppressed; it still takes
// the full latency and completes with done=1, err=1 and no RAM/rd_data change.
// -----------------------------------------------------------------------------
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LDR,
    input  logic              STR,
    input  logic              RW,
    input  logic [WORD_W-1:0] add_bus,
    input  logic [WORD_W-1:0] data_bus,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int         DEPTH     = 2 ** ADDR_W;
    // The counter is loaded one below WAIT_STATES because the accept edge
    // itself is the first wait cycle.
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] idx_q,      idx_d;
    logic [WORD_W-1:0] wdata_q,    wdata_d;
    logic [3:0]        op_q,       op_d;
    logic              fault_q,    fault_d;
    logic [WORD_W-1:0] rd_data_q,  rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              ram_we;
    logic              addr_fault;

    logic [WORD_W-1:0] ram [DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    assign addr_fault = (add_bus[1:0] != 2'b00) ||
                        (add_bus[WORD_W-1:ADDR_W+2] != '0);
`else
    // Byte-offset and high address bits are ignored; the index wraps.
    logic addr_bits_unused;
    assign addr_bits_unused = ^{add_bus[1:0], add_bus[WORD_W-1:ADDR_W+2]};
    assign addr_fault       = 1'b0;
`endif

    wait_counter #(
        .CNT_W (4)
    ) u_wait_counter (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .load_val (WAIT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        fault_d    = fault_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        ram_we     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (LDR || STR) begin
                    if (!req_valid(LDR, STR, RW)) begin
                        // Rejected: report and stay idle, no access.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        idx_d   = add_bus[ADDR_W+1:2];
                        wdata_d = data_bus;
                        op_d    = LDR ? OP_LDR : OP_STR;
                        fault_d = addr_fault;
                        if (WAIT_STATES > 0) begin
                            state_d  = WAIT;
                            cnt_load = 1'b1;
                        end else begin
                            state_d = ACCESS;
                        end
                    end
                end
            end

            WAIT: begin
                if (cnt_zero) begin
                    state_d = ACCESS;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ACCESS: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (fault_q) begin
                    err_d = 1'b1;
                end else if (op_q == OP_LDR) begin
                    rd_data_d  = ram[idx_q];
                    rd_valid_d = 1'b1;
                end else begin
                    ram_we = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wdata_q    <= '0;
            op_q       <= '0;
            fault_q    <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            fault_q    <= fault_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the RAM array has no reset; clearing it would turn the memory into
    // a flop bank. A reset during an access forces state_q to IDLE, which drops
    // ram_we, so an aborted store never reaches the array.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

endmodule : data_mem_unit

// File: tb/tb_data_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_data_mem_unit
// Self-checking bench for data_mem_unit. A WAIT_STATES=2 instance carries the
// directed and random traffic; a WAIT_STATES=0 instance shares its inputs and
// is examined for back-to-back throughput. Expected data comes from a word
// array model indexed by the byte address.
// -----------------------------------------------------------------------------
module tb_data_mem_unit;

    localparam int WS  = 2;
    localparam int AW  = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LDR, STR, RW;
    logic [31:0] add_bus, data_bus;

    logic [31:0] rd_data,  rd_data0;
    logic        rd_valid, rd_valid0;
    logic        done,     done0;
    logic        busy,     busy0;
    logic        err,      err0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [31:0] ram_m [2**AW];
    logic [31:0] last_rd;
    int          wq [$];

    always #5 Clk = ~Clk;

    data_mem_unit #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset), .LDR(LDR), .STR(STR), .RW(RW),
        .add_bus(add_bus), .data_bus(data_bus),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy), .err(err)
    );

    data_mem_unit #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .LDR(LDR), .STR(STR), .RW(RW),
        .add_bus(add_bus), .data_bus(data_bus),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .done(done0), .busy(busy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for exactly one rising edge (the accept edge E0).
    task automatic issue(input logic l, input logic s, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge Clk);
        LDR = l; STR = s; RW = r; add_bus = a; data_bus = d;
        @(posedge Clk);
        #1;
        LDR = 1'b0; STR = 1'b0;
    endtask

    // Cycles from E0 until done is seen; -1 if the bound expires.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // One accepted access on the WS=2 instance with full completion checks.
    task automatic xfer(input string tag, input logic is_load, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
        int lat;
        issue(is_load, !is_load, is_load, a, d);
        check({tag, ".busy_e0"}, {31'd0, busy}, 32'd1);
        wait_done(lat);
        check({tag, ".latency"}, 32'(lat), 32'(WS + 1));
        check({tag, ".err"},      {31'd0, err}, {31'd0, exp_err});
        check({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, is_load && !exp_err});
        check({tag, ".rd_data"},  rd_data, exp_rd);
        check({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        @(posedge Clk);
        #1;
        check({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, d, tmp, exp_err_word;
        logic [7:0]  ix;
        logic        do_store;
        int          vcnt, lat;

        LDR = 0; STR = 0; RW = 0; add_bus = 0; data_bus = 0;
        Reset = 1'b1;
        last_rd = 32'd0;
        #3 Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst.rd_data",  rd_data, 32'd0);
        check("rst.rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst.done",     {31'd0, done}, 32'd0);
        check("rst.busy",     {31'd0, busy}, 32'd0);
        check("rst.err",      {31'd0, err}, 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        // Store then load the same word.
        xfer("st10", 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, last_rd);
        ram_m[4] = 32'hDEADBEEF;
        last_rd = ram_m[4];
        xfer("ld10", 1'b1, 32'h10, 32'h0, 1'b0, last_rd);

        // LDR and STR together: rejected, RAM untouched.
        issue(1'b1, 1'b1, 1'b0, 32'h10, 32'h55555555);
        check("both.err",  {31'd0, err},  32'd1);
        check("both.done", {31'd0, done}, 32'd1);
        check("both.busy", {31'd0, busy}, 32'd0);
        @(posedge Clk);
        #1;
        check("both.err_pulse", {31'd0, err}, 32'd0);

        // Direction mismatch: LDR with RW=0.
        issue(1'b1, 1'b0, 1'b0, 32'h10, 32'h66666666);
        check("mis.err",  {31'd0, err}, 32'd1);
        check("mis.busy", {31'd0, busy}, 32'd0);
        check("mis.rd_data", rd_data, last_rd);
        @(posedge Clk);
        xfer("ld10b", 1'b1, 32'h10, 32'h0, 1'b0, last_rd);

        // Reset one cycle before the ACCESS edge aborts the store.
        xfer("st20", 1'b0, 32'h20, 32'hCAFE0020, 1'b0, last_rd);
        ram_m[8] = 32'hCAFE0020;
        issue(1'b0, 1'b1, 1'b0, 32'h20, 32'h1234);
        @(posedge Clk);          // E1
        @(posedge Clk);          // E2
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("abort.busy",     {31'd0, busy}, 32'd0);
        check("abort.rd_data",  rd_data, 32'd0);
        check("abort.done",     {31'd0, done}, 32'd0);
        @(posedge Clk);          // E3 held in reset
        @(negedge Clk);
        Reset = 1'b1;
        last_rd = ram_m[8];
        xfer("ld20", 1'b1, 32'h20, 32'h0, 1'b0, last_rd);

        // LDR held high through a busy access.
        @(negedge Clk);
        LDR = 1'b1; STR = 1'b0; RW = 1'b1; add_bus = 32'h10;
        @(posedge Clk);
        #1;
        check("hold.busy_e0", {31'd0, busy}, 32'd1);
        vcnt = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge Clk);
            #1;
            vcnt += int'(rd_valid);
        end
        check("hold.valid_count", 32'(vcnt), 32'd1);
        check("hold.rd_data", rd_data, ram_m[4]);
        @(posedge Clk);
        #1;
        check("hold.reaccept", {31'd0, busy}, 32'd1);
        LDR = 1'b0;
        wait_done(lat);
        check("hold.latency2", 32'(lat), 32'(WS + 1));
        check("hold.valid2", {31'd0, rd_valid}, 32'd1);
        last_rd = ram_m[4];

        // Index wrap vs bounds check.
        xfer("st000", 1'b0, 32'h000, 32'h11111111, 1'b0, last_rd);
        ram_m[0] = 32'h11111111;
`ifdef MEM_BOUNDS_CHECK_EN
        xfer("st400", 1'b0, 32'h400, 32'hA5, 1'b1, last_rd);
`else
        xfer("st400", 1'b0, 32'h400, 32'hA5, 1'b0, last_rd);
        ram_m[0] = 32'hA5;
`endif
        last_rd = ram_m[0];
        xfer("ld000", 1'b1, 32'h000, 32'h0, 1'b0, last_rd);

        // Random traffic against the model.
        wq.push_back(0); wq.push_back(4); wq.push_back(8);
        for (int i = 0; i < 24; i++) begin
            do_store = ($urandom_range(0, 1) == 1);
            if (do_store) begin
                ix = 8'($urandom_range(0, 255));
                wq.push_back(int'(ix));
            end else begin
                ix = 8'(wq[$urandom_range(0, wq.size() - 1)]);
            end
            d   = $urandom;
            tmp = $urandom;
`ifdef MEM_BOUNDS_CHECK_EN
            a = {22'd0, ix, 2'b00};
`else
            a = (tmp & 32'hFFFF_FC03) | {22'd0, ix, 2'b00};
`endif
            exp_err_word = 32'd0;
            if (do_store) begin
                xfer("rnd_st", 1'b0, a, d, exp_err_word[0], last_rd);
                ram_m[ix] = d;
            end else begin
                last_rd = ram_m[ix];
                xfer("rnd_ld", 1'b1, a, 32'h0, exp_err_word[0], last_rd);
            end
        end

        // WAIT_STATES=0 instance: held loads give rd_valid every 2 cycles,
        // busy high one cycle per access.
        xfer("st3f0", 1'b0, 32'h3F0, 32'h0BADF00D, 1'b0, last_rd);
        ram_m[8'hFC] = 32'h0BADF00D;
        @(negedge Clk);
        LDR = 1'b1; STR = 1'b0; RW = 1'b1; add_bus = 32'h3F0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk);
            #1;
            check("ws0.busy",     {31'd0, busy0},     {31'd0, (k % 2) == 0});
            check("ws0.rd_valid", {31'd0, rd_valid0}, {31'd0, (k % 2) == 1});
            if ((k % 2) == 1) begin
                check("ws0.rd_data", rd_data0, ram_m[8'hFC]);
            end
        end
        LDR = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        check("ws0.idle", {31'd0, busy0}, 32'd0);
        check("ws2.idle", {31'd0, busy},  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_data_mem_unit

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Data-memory stage directly downstream of memory_control.
- Consumes LDR/STR/RW, add_bus and data_bus.
- Performs the word access on an internal synchronous RAM with a programmable number of wait states.
- Returns load data with a one-cycle valid strobe, and holds busy so the pipeline stalls during the access.

Parameters:
- ADDR_W, 8, word-index width; RAM depth = 2**ADDR_W words of 32 bits.
- WAIT_STATES, 2, extra cycles between accept and access (legal 0..15).

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LDR  in  1  load request from memory_control.
- STR  in  1  store request from memory_control.
- RW  in  1  direction: 1 = read, 0 = write.
- add_bus  in  32  byte address.
- data_bus  in  32  store data.
- rd_data  out  32  load result, registered.
- rd_valid  out  1  one-cycle pulse: rd_data is valid.
- done  out  1  one-cycle pulse: access (load or store) complete.
- busy  out  1  access in progress; upstream must hold or stall.
- err  out  1  one-cycle pulse: request rejected or faulted.

Behaviour:
- Reset: Reset low asynchronously forces state=IDLE, rd_data=0, rd_valid=0, done=0, busy=0, err=0, wait counter=0. RAM contents are not cleared.
- Reset asserted mid-access aborts the access; a pending store is NOT written.
- Request: req = LDR | STR, sampled only on a rising edge in IDLE.
- LDR & STR both high in IDLE: request rejected. err=1 and done=1 for one cycle; no access; state stays IDLE.
- Direction mismatch (LDR with RW=0, or STR with RW=1): request rejected exactly as above.
- Accept at edge E0: latch word index = add_bus[ADDR_W+1:2], store data and direction. busy=1 from E0.
- States:
  - IDLE -> WAIT if WAIT_STATES>0, else IDLE -> ACCESS.
  - WAIT: counter loads WAIT_STATES-1 at E0, decrements each edge; at 0 -> ACCESS.
  - ACCESS: one cycle, then -> IDLE.
- Access at edge E(WAIT_STATES+1):
  - Store writes RAM[index] = latched data.
  - Load registers rd_data = RAM[index]; rd_valid=1.
  - done=1 for both load and store; busy=0 from this edge.
- Latency: accept to done = WAIT_STATES+1 cycles. Throughput: one access per WAIT_STATES+2 cycles.
- rd_data holds its last load value until the next load completes; stores do not alter it.
- Requests while busy are ignored, not queued.
- Upstream must deassert LDR/STR in the cycle done is seen; a request still high at the next IDLE edge is a new access.
- Load after store to the same address returns the stored value (store completes first).
- Index wraps modulo 2**ADDR_W.
- Address bits [1:0] and bits above ADDR_W+1 are ignored unless the optional feature is on.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined: the access is suppressed when add_bus[1:0] != 0 or any add_bus bit above ADDR_W+1 is set.
  - Timing still runs the full WAIT_STATES+1 cycles.
  - At completion: done=1, err=1, rd_valid=0; RAM and rd_data unchanged.
- Undefined: no check, wrap/ignore behaviour as above; err is driven only by rejected requests.

Decomposition:
- Package mem_pkg:
  - opcodes OP_LDR=4'b1101, OP_STR=4'b1110;
  - WORD_W=32;
  - state encoding IDLE/WAIT/ACCESS;
  - RW_READ=1, RW_WRITE=0.
- Sub-module wait_counter (load, decrement, zero flag, async active-low reset), instantiated once.

Test Plan:
- WAIT_STATES=2: STR RW=0 add_bus=0x10 data_bus=0xDEADBEEF, then LDR RW=1 add_bus=0x10 -> store done 3 cycles after accept; load rd_valid 3 cycles after its accept, rd_data=0xDEADBEEF.
- LDR=1 and STR=1 together in IDLE -> err and done pulse next cycle, busy stays 0, RAM[addr] unchanged.
- Reset driven low one cycle before a store's ACCESS edge (addr 0x20, data 0x1234) -> outputs zero immediately; later load of 0x20 returns the old value.
- Second LDR held high while busy -> ignored; exactly one rd_valid, then a new accept on the first IDLE edge.
- ADDR_W=8: store 0xA5 to 0x400, load 0x000 -> 0xA5 when the macro is undefined; with MEM_BOUNDS_CHECK_EN, err=1 on the store and 0x000 is unchanged.
- WAIT_STATES=0: back-to-back loads -> rd_valid every 2 cycles, busy high exactly 1 cycle per access.
